// File: rtl/unary_bin_decoder_pkg.sv
// Shared definitions for the unary-to-binary decoder: FSM state encodings and defaults.
// Imported by unary_bin_decoder and ucnt_window.
package unary_bin_decoder_pkg;

   localparam int BITWIDTH_DEFAULT = 8;

   // Encoding 2'd3 is unused and recovers to IDLE.
   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_RUN     = 2'd1,
      ST_DONE    = 2'd2,
      ST_ILLEGAL = 2'd3
   } udec_state_e;

   function automatic logic is_start_state(input udec_state_e st);
      return (st == ST_IDLE) || (st == ST_DONE);
   endfunction

endpackage

// File: rtl/ucnt_window.sv
// Window sample counter and ones accumulator for the unary decoder.
// oLast flags the final sample of a 2^BITWIDTH window; the counter wraps to 0 afterwards.
module ucnt_window
   import unary_bin_decoder_pkg::*;
#(
   parameter int BITWIDTH = BITWIDTH_DEFAULT
) (
   input  logic              iClk,
   input  logic              iRstN,
   input  logic              iClr,
   input  logic              iEn,
   input  logic              iA,
   output logic [BITWIDTH:0] oOnes,
   output logic              oLast
);

   logic [BITWIDTH-1:0] cnt_q, cnt_d;
   logic [BITWIDTH:0]   ones_q, ones_d;

   always_comb begin
      cnt_d  = cnt_q;
      ones_d = ones_q;
      if (iClr) begin
         cnt_d  = '0;
         ones_d = '0;
      end else if (iEn) begin
         cnt_d  = cnt_q + 1'b1;
         ones_d = ones_q + {{BITWIDTH{1'b0}}, iA};
      end
   end

   always_ff @(posedge iClk or negedge iRstN) begin
      if (!iRstN) begin
         cnt_q  <= '0;
         ones_q <= '0;
      end else begin
         cnt_q  <= cnt_d;
         ones_q <= ones_d;
      end
   end

   assign oOnes = ones_q;
   assign oLast = &cnt_q;

endmodule

// File: rtl/unary_bin_decoder.sv
// Unary bitstream to binary converter: counts ones over a 2^BITWIDTH window.
// Define BIPOLAR_EN to output the two's-complement value ones - 2^(BITWIDTH-1).
module unary_bin_decoder
   import unary_bin_decoder_pkg::*;
#(
   parameter int BITWIDTH = BITWIDTH_DEFAULT
) (
   input  logic              iClk,
   input  logic              iRstN,
   input  logic              iClr,
   input  logic              iStart,
   input  logic              iA,
   output logic              oBusy,
   output logic              oValid,
   output logic [BITWIDTH:0] oData
);

   udec_state_e       state_q;
   logic              busy_q;
   logic              valid_q;
   logic [BITWIDTH:0] data_q;

   logic              start_accept;
   logic              cnt_clr;
   logic              cnt_en;
   logic              last_sample;
   logic [BITWIDTH:0] ones;
   logic [BITWIDTH:0] window_sum;
   logic [BITWIDTH:0] result_d;

   assign start_accept = iStart && is_start_state(state_q);
   assign cnt_clr      = iClr || start_accept;
   assign cnt_en       = (state_q == ST_RUN);

   ucnt_window #(
      .BITWIDTH(BITWIDTH)
   ) u_window (
      .iClk (iClk),
      .iRstN(iRstN),
      .iClr (cnt_clr),
      .iEn  (cnt_en),
      .iA   (iA),
      .oOnes(ones),
      .oLast(last_sample)
   );

   // The final sample is folded in combinationally so the result lands on the same edge.
   assign window_sum = ones + {{BITWIDTH{1'b0}}, iA};

`ifdef BIPOLAR_EN
   localparam logic [BITWIDTH:0] BIAS = (BITWIDTH+1)'(1) << (BITWIDTH - 1);
   assign result_d = window_sum - BIAS;
`else
   assign result_d = window_sum;
`endif

   always_ff @(posedge iClk or negedge iRstN) begin
      if (!iRstN) begin
         state_q <= ST_IDLE;
         busy_q  <= 1'b0;
         valid_q <= 1'b0;
         data_q  <= '0;
      end else if (iClr) begin
         state_q <= ST_IDLE;
         busy_q  <= 1'b0;
         valid_q <= 1'b0;
         data_q  <= '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               valid_q <= 1'b0;
               if (iStart) begin
                  state_q <= ST_RUN;
                  busy_q  <= 1'b1;
               end
            end
            ST_RUN: begin
               if (last_sample) begin
                  state_q <= ST_DONE;
                  busy_q  <= 1'b0;
                  valid_q <= 1'b1;
                  data_q  <= result_d;
               end
            end
            ST_DONE: begin
               valid_q <= 1'b0;
               if (iStart) begin
                  state_q <= ST_RUN;
                  busy_q  <= 1'b1;
               end else begin
                  state_q <= ST_IDLE;
                  busy_q  <= 1'b0;
               end
            end
            default: begin
               state_q <= ST_IDLE;
               busy_q  <= 1'b0;
               valid_q <= 1'b0;
            end
         endcase
      end
   end

   assign oBusy  = busy_q;
   assign oValid = valid_q;
   assign oData  = data_q;

endmodule

// File: tb/tb_unary_bin_decoder.sv
// Randomized self-checking bench for unary_bin_decoder with a 16-sample window.
// Define BIPOLAR_EN for both bench and RTL to check the bipolar output mode.
module tb_unary_bin_decoder;

   localparam int BW  = 4;
   localparam int WIN = 1 << BW;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          clr = 1'b0;
   logic          start = 1'b0;
   logic          a = 1'b0;
   logic          busy;
   logic          valid;
   logic [BW:0]   data;

   int            n_checks = 0;
   int            n_pass = 0;
   logic [BW:0]   last_result = '0;

   unary_bin_decoder #(
      .BITWIDTH(BW)
   ) dut (
      .iClk  (clk),
      .iRstN (rst_n),
      .iClr  (clr),
      .iStart(start),
      .iA    (a),
      .oBusy (busy),
      .oValid(valid),
      .oData (data)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   // Reference: the window result is just the population count of the samples.
   function automatic logic [BW:0] model(input logic [WIN-1:0] pat);
      int ones;
      ones = $countones(pat);
`ifdef BIPOLAR_EN
      ones = ones - WIN / 2;
`endif
      return ones[BW:0];
   endfunction

   // Caller has set start=1 at a negedge while the DUT is idle or done.
   task automatic run_window(input logic [WIN-1:0] pat, input bit noise, input bit chain_next);
      logic [BW:0] exp;
      exp = model(pat);
      for (int i = 0; i < WIN; i++) begin
         @(negedge clk);
         chk("busy_run", 32'(busy), 32'd1);
         chk("valid_run", 32'(valid), 32'd0);
         chk("hold_run", 32'(data), 32'(last_result));
         start = noise ? 1'($urandom_range(1)) : 1'b0;
         a = pat[i];
      end
      @(negedge clk);
      chk("valid_done", 32'(valid), 32'd1);
      chk("busy_done", 32'(busy), 32'd0);
      chk("data_done", 32'(data), 32'(exp));
      $display("window pat=%h ones=%0d data=%0h exp=%0h", pat, $countones(pat), data, exp);
      last_result = exp;
      start = chain_next;
      a = 1'($urandom_range(1));
   endtask

   task automatic idle_check(input int cycles);
      for (int i = 0; i < cycles; i++) begin
         @(negedge clk);
         chk("valid_idle", 32'(valid), 32'd0);
         chk("busy_idle", 32'(busy), 32'd0);
         chk("data_hold", 32'(data), 32'(last_result));
         start = 1'b0;
         a = 1'($urandom_range(1));
      end
   endtask

   initial begin
      logic [WIN-1:0] pat;
      logic [31:0]    rot;

      // Reset state
      repeat (3) @(negedge clk);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_valid", 32'(valid), 32'd0);
      chk("rst_data", 32'(data), 32'd0);
      rst_n = 1'b1;
      idle_check(2);

      // All ones, all zeros, alternating 1,0
      start = 1'b1; run_window({WIN{1'b1}}, 1'b0, 1'b0); idle_check(2);
      start = 1'b1; run_window('0, 1'b0, 1'b0); idle_check(2);
      start = 1'b1; run_window(16'h5555, 1'b0, 1'b0); idle_check(2);

      // Abort on the 5th RUN cycle, with a simultaneous start that must lose
      start = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         start = 1'b0;
         a = 1'b1;
      end
      @(negedge clk);
      clr = 1'b1;
      start = 1'b1;
      @(negedge clk);
      clr = 1'b0;
      start = 1'b0;
      chk("clr_busy", 32'(busy), 32'd0);
      chk("clr_valid", 32'(valid), 32'd0);
      chk("clr_data", 32'(data), 32'd0);
      last_result = '0;
      idle_check(20);
      start = 1'b1; run_window({WIN{1'b1}}, 1'b0, 1'b0); idle_check(1);

      // Back-to-back windows with start toggling during RUN
      start = 1'b1;
      for (int k = 0; k < 4; k++) begin
         pat = WIN'($urandom);
         run_window(pat, 1'b1, k < 3);
      end
      idle_check(2);

      // Asynchronous reset mid-window
      start = 1'b1;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         start = 1'b0;
         a = 1'b1;
      end
      #2 rst_n = 1'b0;
      #1;
      chk("arst_busy", 32'(busy), 32'd0);
      chk("arst_valid", 32'(valid), 32'd0);
      chk("arst_data", 32'(data), 32'd0);
      last_result = '0;
      @(negedge clk);
      rst_n = 1'b1;
      idle_check(2);
      rot = {16'h0FFF, 16'h0FFF} >> $urandom_range(15);
      start = 1'b1; run_window(rot[WIN-1:0], 1'b0, 1'b0); idle_check(1);

      // Random windows separated by random idle gaps
      for (int k = 0; k < 6; k++) begin
         pat = WIN'($urandom);
         start = 1'b1;
         run_window(pat, 1'b1, 1'b0);
         idle_check(1 + $urandom_range(3));
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
